// File: rtl/dadda_pkg.sv
// Shared types and helpers for the Dadda multiplier product accumulator.
package dadda_pkg;

    // Accumulator run states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Product width of the 4x4 Dadda multiplier feeding this stage.
    localparam int PROD_W_DEF = 8;

    // Accumulator width needed to sum n_terms products of prod_w bits without saturating.
    function automatic int acc_w_min(input int prod_w, input int n_terms);
        return prod_w + $clog2(n_terms);
    endfunction

endpackage

// File: rtl/dadda_product_accumulator.sv
// Sequential accumulator for the Dadda multiplier products.
// It sums a run of up to N_TERMS unsigned products into a saturating
// ACC_W-bit sum. The finished sum, the term count and the overflow flag
// are handed off over a valid/ready handshake. While a result waits in
// DONE no input is taken, which costs one bubble per run.
module dadda_product_accumulator
    import dadda_pkg::*;
#(
    parameter int PROD_W  = PROD_W_DEF,
    parameter int N_TERMS = 4,
    parameter int ACC_W   = 12,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf
);

    // Reject parameter sets the datapath cannot represent.
    if (ACC_W < PROD_W) begin : g_bad_acc_w
        $error("dadda_product_accumulator: ACC_W must be at least PROD_W");
    end
    if (N_TERMS < 1 || N_TERMS > (2 ** CNT_W) - 1) begin : g_bad_n_terms
        $error("dadda_product_accumulator: N_TERMS must lie in 1..2**CNT_W-1");
    end

    localparam logic [CNT_W-1:0] N_TERMS_C = CNT_W'(N_TERMS);

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;

    logic               in_fire;
    logic               out_fire;
    logic [ACC_W:0]     sum_wide;
    logic [CNT_W-1:0]   cnt_inc;

    assign in_ready  = (state_q != DONE);
    assign out_valid = (state_q == DONE);
    assign out_sum   = acc_q;
    assign out_count = cnt_q;
    assign out_ovf   = ovf_q;

    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign sum_wide  = {1'b0, acc_q} + (ACC_W + 1)'(in_prod);
    assign cnt_inc   = cnt_q + CNT_W'(1);

    // Next-state and datapath update: load on first term, saturating add after, clear on hand-off.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_fire) begin
                    acc_d   = ACC_W'(in_prod);
                    cnt_d   = CNT_W'(1);
                    ovf_d   = 1'b0;
                    state_d = (in_last || N_TERMS == 1) ? DONE : ACC;
                end
            end
            ACC: begin
                if (in_fire) begin
                    if (sum_wide[ACC_W]) begin
                        acc_d = '1;
                        ovf_d = 1'b1;
                    end else begin
                        acc_d = sum_wide[ACC_W-1:0];
                    end
                    cnt_d = cnt_inc;
                    if (in_last || cnt_inc == N_TERMS_C) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_fire) begin
                    state_d = IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any partial run at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_dadda_product_accumulator.sv
// Self-checking bench for dadda_product_accumulator.
// A default instance (ACC_W=12) and a narrow instance (ACC_W=9) share all
// inputs. Both have the same N_TERMS, so their handshake timing is identical.
module tb_dadda_product_accumulator;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_prod;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_sum;
    logic [7:0]  out_count;
    logic        out_ovf;

    logic        in_ready9;
    logic        out_valid9;
    logic [8:0]  out_sum9;
    logic [7:0]  out_count9;
    logic        out_ovf9;

    int checks   = 0;
    int failures = 0;

    dadda_product_accumulator #(.PROD_W(8), .N_TERMS(4), .ACC_W(12), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_prod(in_prod), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_count(out_count), .out_ovf(out_ovf)
    );

    dadda_product_accumulator #(.PROD_W(8), .N_TERMS(4), .ACC_W(9), .CNT_W(8)) dut9 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready9), .in_prod(in_prod), .in_last(in_last),
        .out_valid(out_valid9), .out_ready(out_ready),
        .out_sum(out_sum9), .out_count(out_count9), .out_ovf(out_ovf9)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int n;
        int p[4];
        bit lastFinal;
        int expSum;
        int expCnt;
        bit expOvf;
        int expSum9;
        bit expOvf9;
    } vec_t;

    vec_t vecs[7];

    // Compare one value and report a FAIL line on mismatch.
    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference: plain sum of the run, clamped to all ones of the given width.
    function automatic int modelSum(input int q[$], input int accw, output bit ovf);
        longint total = 0;
        longint maxv  = (longint'(1) << accw) - 1;
        foreach (q[i]) total += q[i];
        ovf = (total > maxv);
        return ovf ? int'(maxv) : int'(total);
    endfunction

    // Drive one run of products. Each term may be preceded by up to maxGap idle cycles.
    // On return the final term has been transferred and time is 1 ns after that edge.
    task automatic applyStimulus(input int prods[$], input bit lastFinal, input int maxGap);
        for (int i = 0; i < prods.size(); i++) begin
            int gap;
            bit accepted;
            int waitCnt;
            gap = (maxGap > 0) ? int'($urandom_range(0, maxGap)) : 0;
            in_valid = 1'b0;
            repeat (gap) begin @(posedge clk); #1; end
            in_valid = 1'b1;
            in_prod  = 8'(prods[i]);
            in_last  = lastFinal && (i == prods.size() - 1);
            accepted = 1'b0;
            waitCnt  = 0;
            while (!accepted && waitCnt < 50) begin
                accepted = in_ready;
                @(posedge clk); #1;
                waitCnt++;
            end
            if (!accepted) begin
                checkOutput("in_handshake_timeout", 0, 1);
                break;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Wait (bounded) for a result, optionally stall out_ready, then accept it.
    task automatic collectResult(input int readyDelay, output int s, output int c, output bit o,
                                 output int s9, output bit o9);
        int n = 0;
        while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
        checkOutput("out_valid_seen", out_valid, 1);
        s = out_sum; c = out_count; o = out_ovf; s9 = out_sum9; o9 = out_ovf9;
        if (readyDelay > 0) begin
            out_ready = 1'b0;
            repeat (readyDelay) begin
                @(posedge clk); #1;
                checkOutput("stall_sum_stable", out_sum, s);
                checkOutput("stall_valid_held", out_valid, 1);
            end
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
    endtask

    int q[$];
    int s, c, s9;
    bit o, o9, mOvf, mOvf9;
    int mSum, mSum9;

    initial begin
        vecs[0] = '{4, '{10, 20, 30, 40},    1'b0, 100,  4, 1'b0, 100, 1'b0};
        vecs[1] = '{2, '{225, 225, 0, 0},    1'b1, 450,  2, 1'b0, 450, 1'b0};
        vecs[2] = '{1, '{99, 0, 0, 0},       1'b1, 99,   1, 1'b0, 99,  1'b0};
        vecs[3] = '{4, '{225, 225, 225, 225}, 1'b0, 900, 4, 1'b0, 511, 1'b1};
        vecs[4] = '{4, '{1, 1, 1, 1},        1'b0, 4,    4, 1'b0, 4,   1'b0};
        vecs[5] = '{4, '{255, 255, 255, 255}, 1'b1, 1020, 4, 1'b0, 511, 1'b1};
        vecs[6] = '{3, '{0, 0, 7, 0},        1'b1, 7,    3, 1'b0, 7,   1'b0};

        rst_n = 1'b0; in_valid = 1'b0; in_prod = '0; in_last = 1'b0; out_ready = 1'b1;
        #12;
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_in_ready", in_ready, 1);
        checkOutput("reset_out_sum", out_sum, 0);
        checkOutput("reset_out_count", out_count, 0);
        checkOutput("reset_out_ovf", out_ovf, 0);
        #5 rst_n = 1'b1;
        @(posedge clk); #1;

        // Table-driven runs, back-to-back, out_ready held high.
        foreach (vecs[k]) begin
            q.delete();
            for (int i = 0; i < vecs[k].n; i++) q.push_back(vecs[k].p[i]);
            applyStimulus(q, vecs[k].lastFinal, 0);
            checkOutput("latency_out_valid", out_valid, 1);
            checkOutput("done_in_ready_low", in_ready, 0);
            collectResult(0, s, c, o, s9, o9);
            checkOutput("vec_sum", s, vecs[k].expSum);
            checkOutput("vec_count", c, vecs[k].expCnt);
            checkOutput("vec_ovf", o, vecs[k].expOvf);
            checkOutput("vec_sum9", s9, vecs[k].expSum9);
            checkOutput("vec_ovf9", o9, vecs[k].expOvf9);
            checkOutput("bubble_in_ready_back", in_ready, 1);
            checkOutput("after_xfer_valid_low", out_valid, 0);
            checkOutput("after_xfer_acc_clear", out_sum, 0);
            checkOutput("after_xfer_cnt_clear", out_count, 0);
        end

        // Output stall with an offered product that must not be absorbed.
        q = '{1, 2, 3, 4};
        applyStimulus(q, 1'b0, 0);
        out_ready = 1'b0;
        in_valid = 1'b1; in_prod = 8'd99; in_last = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            checkOutput("stall_out_sum", out_sum, 10);
            checkOutput("stall_in_ready", in_ready, 0);
            checkOutput("stall_out_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("stall_release_valid", out_valid, 0);
        checkOutput("stall_release_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
        checkOutput("single_99_valid", out_valid, 1);
        checkOutput("single_99_sum", out_sum, 99);
        checkOutput("single_99_count", out_count, 1);
        @(posedge clk); #1;

        // Asynchronous reset in the middle of a run.
        q = '{50, 60};
        applyStimulus(q, 1'b0, 0);
        checkOutput("partial_sum", out_sum, 110);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_rst_sum", out_sum, 0);
        checkOutput("async_rst_count", out_count, 0);
        checkOutput("async_rst_valid", out_valid, 0);
        checkOutput("async_rst_ovf", out_ovf, 0);
        checkOutput("async_rst_ready", in_ready, 1);
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;
        q = '{1, 2, 3, 4};
        applyStimulus(q, 1'b0, 0);
        collectResult(0, s, c, o, s9, o9);
        checkOutput("post_rst_sum", s, 10);
        checkOutput("post_rst_count", c, 4);

        // Input gaps must not change the result.
        q = '{7, 8, 9, 10};
        applyStimulus(q, 1'b0, 3);
        collectResult(0, s, c, o, s9, o9);
        checkOutput("gap_sum", s, 34);
        checkOutput("gap_count", c, 4);

        // Randomised runs against the reference model.
        for (int r = 0; r < 20; r++) begin
            int len;
            len = int'($urandom_range(1, 4));
            q.delete();
            for (int i = 0; i < len; i++) q.push_back(int'($urandom_range(0, 255)));
            mSum  = modelSum(q, 12, mOvf);
            mSum9 = modelSum(q, 9, mOvf9);
            applyStimulus(q, (len < 4) ? 1'b1 : 1'($urandom_range(0, 1)), 3);
            collectResult(int'($urandom_range(0, 2)), s, c, o, s9, o9);
            checkOutput("rand_sum", s, mSum);
            checkOutput("rand_count", c, len);
            checkOutput("rand_ovf", o, mOvf);
            checkOutput("rand_sum9", s9, mSum9);
            checkOutput("rand_ovf9", o9, mOvf9);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
